// File: rtl/rsff_pkg.sv
// rsff_pkg: state encoding, {S,R} command decode and next-state rule shared by the RS latch monitor.
package rsff_pkg;
  typedef enum logic [1:0] {UNK, Q0, Q1, BAD} state_t;
  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_FORBID = 2'b11;
  function automatic state_t next_state(input state_t cur, input logic [1:0] cmd);
    return cmd == CMD_SET ? Q1 : cmd == CMD_RESET ? Q0 : cmd == CMD_FORBID ? BAD : cur == BAD ? UNK : cur;
  endfunction
endpackage

// File: rtl/rsff_monitor_sat_cnt.sv
// sat_cnt: saturating event counter with synchronous clear; a clear coinciding with an event yields 1.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? W'(inc) : cnt + W'(inc && cnt != '1);
endmodule

// File: rtl/rsff_monitor.sv
// rsff_monitor: tracks the expected state of an RS latch and flags Q/Q_B mismatches after a settle window.
// Define RSFF_MON_COV_EN to add SET_CNT/RST_CNT counters of state-changing SET/RESET commands.
module rsff_monitor
  import rsff_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             R,
  input  logic             S,
  input  logic             Q,
  input  logic             Q_B,
  input  logic             CLR,
  output logic             EXP_Q,
  output logic             EXP_VLD,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             ILLEGAL
`ifdef RSFF_MON_COV_EN
  ,
  output logic [CNT_W-1:0] SET_CNT,
  output logic [CNT_W-1:0] RST_CNT
`endif
);
  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  state_t     state, nstate;
  logic [3:0] cnt, eff;
  logic [1:0] cmd;
  logic       chg, mis;
  // A state change reloads the window, so SETTLE=0 checks on the changing edge itself.
  always_comb begin
    cmd    = {S, R};
    nstate = next_state(state, cmd);
    chg    = nstate != state;
    eff    = chg ? SETTLE_V : cnt;
    mis    = eff == '0 && (nstate == UNK ? Q_B == Q : nstate != BAD && (Q != (nstate == Q1) || Q_B == Q));
  end
  always_ff @(posedge CLK or negedge RST_B)
    if (!RST_B) begin
      state      <= UNK;
      cnt        <= SETTLE_V;
      ERR        <= 1'b0;
      ILLEGAL    <= 1'b0;
      ERR_STICKY <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= chg ? SETTLE_V : cnt - 4'(cnt != '0);
      ERR        <= mis;
      ILLEGAL    <= S & R;
      ERR_STICKY <= (ERR_STICKY & ~CLR) | mis;
    end
  assign EXP_Q   = state == Q1;
  assign EXP_VLD = state == Q0 || state == Q1;
  sat_cnt #(.W(CNT_W)) u_err_cnt (.clk(CLK), .rst_n(RST_B), .clr(CLR), .inc(mis), .cnt(ERR_CNT));
`ifdef RSFF_MON_COV_EN
  sat_cnt #(.W(CNT_W)) u_set_cnt (.clk(CLK), .rst_n(RST_B), .clr(CLR), .inc(chg && cmd == CMD_SET), .cnt(SET_CNT));
  sat_cnt #(.W(CNT_W)) u_rst_cnt (.clk(CLK), .rst_n(RST_B), .clr(CLR), .inc(chg && cmd == CMD_RESET), .cnt(RST_CNT));
`endif
endmodule

// File: tb/tb_rsff_monitor.sv
// tb_rsff_monitor: directed vectors with hand-computed expectations, scoreboard queue drained by a monitor.
module tb_rsff_monitor;
  logic CLK = 0, RST_B = 0, R = 0, S = 0, Q = 0, Q_B = 0, CLR = 0;
  logic a_eq, a_ev, a_err, a_st, a_ill, b_eq, b_ev, b_err, b_st, b_ill;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
`ifdef RSFF_MON_COV_EN
  logic [7:0] a_set, a_rst;
  logic [1:0] b_set, b_rst;
`endif
  typedef struct packed {
    logic       dut;
    logic [4:0] flags;
    logic [7:0] cnt;
    logic [7:0] row;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [4:0] act_f;
  logic [7:0] act_c;
  int checks = 0, errors = 0, row = 0;

  always #5 CLK = ~CLK;

  rsff_monitor #(.SETTLE(2), .CNT_W(8)) dut_a (
    .CLK(CLK), .RST_B(RST_B), .R(R), .S(S), .Q(Q), .Q_B(Q_B), .CLR(CLR),
    .EXP_Q(a_eq), .EXP_VLD(a_ev), .ERR(a_err), .ERR_STICKY(a_st), .ERR_CNT(a_cnt), .ILLEGAL(a_ill)
`ifdef RSFF_MON_COV_EN
    , .SET_CNT(a_set), .RST_CNT(a_rst)
`endif
  );
  rsff_monitor #(.SETTLE(0), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST_B(RST_B), .R(R), .S(S), .Q(Q), .Q_B(Q_B), .CLR(CLR),
    .EXP_Q(b_eq), .EXP_VLD(b_ev), .ERR(b_err), .ERR_STICKY(b_st), .ERR_CNT(b_cnt), .ILLEGAL(b_ill)
`ifdef RSFF_MON_COV_EN
    , .SET_CNT(b_set), .RST_CNT(b_rst)
`endif
  );

  // flags = {EXP_Q, EXP_VLD, ERR, ILLEGAL, ERR_STICKY} expected after the next rising edge
  task automatic step(input logic rb, s, r, q, qb, clr, d, input logic [4:0] f, input logic [7:0] c);
    @(negedge CLK);
    RST_B = rb; S = s; R = r; Q = q; Q_B = qb; CLR = clr;
    sb.push_back('{d, f, c, 8'(row)});
    row++;
    if (!rb) begin
      #1;
      checks++;
      if ((d ? {b_eq, b_ev, b_err, b_ill, b_st} : {a_eq, a_ev, a_err, a_ill, a_st}) != 5'b0) begin
        errors++;
        $display("FAIL async_reset row %0d dut%0d: outputs not cleared between edges", row - 1, d);
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act_f = e.dut ? {b_eq, b_ev, b_err, b_ill, b_st} : {a_eq, a_ev, a_err, a_ill, a_st};
      act_c = e.dut ? 8'(b_cnt) : a_cnt;
      checks++;
      if ({act_f, act_c} != {e.flags, e.cnt}) begin
        errors++;
        $display("FAIL row %0d dut%0d: got eq/vld/err/ill/sticky=%b cnt=%0d, expected %b cnt=%0d",
                 e.row, e.dut, act_f, act_c, e.flags, e.cnt);
      end
    end
  end

  initial begin
    // DUT A: SETTLE=2, CNT_W=8
    step(0,0,0,0,0,0,0,5'b00000,0);
    step(1,1,0,0,1,0,0,5'b11000,0);
    step(1,0,0,1,0,0,0,5'b11000,0);
    step(1,0,0,1,0,0,0,5'b11000,0);
    step(1,0,0,1,0,0,0,5'b11000,0);
    step(1,0,0,1,0,0,0,5'b11000,0);
    step(1,0,0,0,1,0,0,5'b11101,1);
    step(1,0,0,0,1,0,0,5'b11101,2);
    step(1,0,0,0,1,0,0,5'b11101,3);
    step(1,0,0,1,0,0,0,5'b11001,3);
    step(1,1,1,1,0,0,0,5'b00011,3);
    step(1,1,1,0,0,0,0,5'b00011,3);
    step(1,1,1,0,0,0,0,5'b00011,3);
    step(1,1,1,0,0,0,0,5'b00011,3);
    step(1,0,0,0,0,0,0,5'b00001,3);
    step(1,0,0,1,1,0,0,5'b00001,3);
    step(1,0,0,1,1,0,0,5'b00001,3);
    step(1,0,0,1,1,0,0,5'b00101,4);
    step(1,0,0,0,1,0,0,5'b00001,4);
    step(1,0,0,0,1,1,0,5'b00000,0);
    step(1,1,0,0,1,0,0,5'b11000,0);
    step(1,0,0,1,0,0,0,5'b11000,0);
    step(0,0,0,1,0,0,0,5'b00000,0);
    step(1,0,0,1,1,0,0,5'b00000,0);
    step(1,0,0,1,1,0,0,5'b00000,0);
    step(1,0,0,1,1,0,0,5'b00101,1);
    step(1,1,0,1,0,0,0,5'b11001,1);
    step(1,1,0,1,0,0,0,5'b11001,1);
    step(1,0,1,1,0,0,0,5'b01001,1);
    step(1,1,0,1,0,0,0,5'b11001,1);
    step(1,0,0,1,0,0,0,5'b11001,1);
    repeat (2) @(posedge CLK);
    #2;
`ifdef RSFF_MON_COV_EN
    checks++;
    if (a_set != 8'd2 || a_rst != 8'd1) begin
      errors++;
      $display("FAIL cov_counts: got set=%0d rst=%0d, expected set=2 rst=1", a_set, a_rst);
    end
`endif
    // DUT B: SETTLE=0, CNT_W=2
    step(0,0,0,0,0,0,1,5'b00000,0);
    step(1,1,0,0,1,0,1,5'b11101,1);
    step(1,0,0,1,0,0,1,5'b11001,1);
    step(1,0,0,0,1,0,1,5'b11101,2);
    step(1,0,0,0,1,0,1,5'b11101,3);
    step(1,0,0,0,1,0,1,5'b11101,3);
    step(1,0,0,0,1,0,1,5'b11101,3);
    step(1,0,0,0,1,1,1,5'b11101,1);
    step(1,0,0,1,0,1,1,5'b11000,0);
    step(1,0,0,1,0,0,1,5'b11000,0);
    repeat (2) @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
